countdown_timer_fsm: RTL and testbench
======================================

Name: countdown_timer_fsm

Overview:
- Parametrised successor to the microwave timer state machine: set, load, count down, pause, then flash on completion.
- Runs on one clock. The prescaler supplies tick and flash_tick as single-cycle enables, so the block has no derived clocks and no button-driven edges.
- Sits between the debounce/edge-detect front end and the display and LED drivers.

Parameters:
TIME_W, 8, width of preset and remaining time (seconds)
MAX_TIME, 255, saturation ceiling for loaded or added time; must be < 2**TIME_W
FLASH_CYCLES, 10, number of on/off LED flash periods in DONE
ADD_STEP, 30, seconds added per add_time pulse (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
tick  in  1  one-cycle pulse at the count rate (1 Hz)
flash_tick  in  1  one-cycle pulse at the LED toggle rate
start_pause  in  1  one-cycle pulse, already debounced and edge-detected
clear  in  1  one-cycle pulse; return to IDLE
set_val  in  TIME_W  switch value captured on load
add_time  in  1  one-cycle pulse; present only when TIMER_ADD30_EN is defined
time_out  out  TIME_W  value to display
state_out  out  3  current state encoding
running  out  1  high while in COUNTING
done  out  1  one-cycle pulse on entry to DONE
done_flash  out  1  completion LED

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; preset=0; remaining=0; time_out=0; running=0; done=0; done_flash=0; flash counter=0.
- All outputs are registered. Each reacts on the clk edge that samples its input pulse (one-cycle latency).
- Input priority in every state: clear > reaching zero > start_pause > tick.
- IDLE (000):
  - time_out=0.
  - start_pause: preset=min(set_val, MAX_TIME) and remaining=preset.
  - If the captured value is non-zero, go to LOADED; if it is 0, stay in IDLE.
- LOADED (001): time_out=preset. start_pause goes to COUNTING. tick is ignored.
- COUNTING (010):
  - time_out=remaining; running=1.
  - tick: remaining-=1.
  - The tick that takes remaining from 1 to 0 moves the state to DONE and pulses done in the same edge, even if start_pause arrives simultaneously.
  - start_pause without a zero-reaching tick goes to PAUSED. If a tick arrives in the same cycle, the decrement is still applied.
  - remaining never wraps below 0.
- PAUSED (011): remaining and time_out are held; tick is ignored. start_pause goes to COUNTING.
- DONE (100):
  - time_out=0. done_flash=1 on entry and toggles on each flash_tick.
  - After 2*FLASH_CYCLES toggles: done_flash=0, remaining=preset, go to LOADED.
  - start_pause in DONE aborts the flash: done_flash=0 and go to LOADED immediately.
- clear in any state goes to IDLE on the next edge and zeroes preset, remaining and done_flash.
- States 101–111 are unreachable. If one is entered, the next edge goes to IDLE.

Optional Feature:
- TIMER_ADD30_EN defined:
  - The add_time port exists.
  - In LOADED, COUNTING or PAUSED, add_time adds ADD_STEP, saturating at MAX_TIME. In LOADED it applies to both preset and remaining; in COUNTING and PAUSED to remaining only.
  - In IDLE, add_time performs a load with value min(ADD_STEP, MAX_TIME) and goes to COUNTING (quick start).
  - add_time is ignored in DONE.
  - If add_time coincides with a zero-reaching tick, the add wins: remaining=ADD_STEP-1 and the state stays in COUNTING.
- TIMER_ADD30_EN undefined: no add_time port and no related logic.

Decomposition:
- Package timer_pkg: state encodings (IDLE, LOADED, COUNTING, PAUSED, DONE) and the STATE_W=3 constant.
- Sub-module done_flasher: owns the toggle counter and done_flash. Interface: start, abort, flash_tick, done_flash, finished.

Test Plan:
- set_val=5, start_pause, start_pause, 5 ticks → time_out 5,4,3,2,1,0; done pulses once; state=DONE; done_flash toggles 20 times, then state=LOADED with time_out=5.
- set_val=200 with MAX_TIME=99 → preset=99. set_val=0 with start_pause → stays IDLE.
- COUNTING at 3, start_pause and tick in the same cycle → remaining=2, state PAUSED. Further ticks leave 2; start_pause resumes COUNTING.
- COUNTING at 1, tick and start_pause in the same cycle → DONE with done pulse; no PAUSED.
- Reset asserted asynchronously mid-COUNTING at 40 → all outputs 0 and IDLE without waiting for a clk edge. clear in PAUSED → IDLE next edge.
- TIMER_ADD30_EN defined: remaining=80 with MAX_TIME=99, add_time → 99. In IDLE, add_time → COUNTING at 30.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared state encodings for the countdown timer FSM and its flasher.
// The optional add-time feature is enabled with TIMER_ADD30_EN.
package timer_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = 3'b000,
        LOADED   = 3'b001,
        COUNTING = 3'b010,
        PAUSED   = 3'b011,
        DONE     = 3'b100
    } state_t;

endpackage

// File: rtl/countdown_timer_fsm_done_flasher.sv
// Completion LED flasher: toggles done_flash on flash_tick for a fixed
// number of periods, then reports finished for one cycle.
module done_flasher
    import timer_pkg::*;
#(
    parameter int FLASH_CYCLES = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic abort,
    input  logic flash_tick,
    output logic done_flash,
    output logic finished
);

    localparam int CNT_W = $clog2(2 * FLASH_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(2 * FLASH_CYCLES - 1);

    logic             active_q, active_d;
    logic             flash_q, flash_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        active_d = active_q;
        flash_d  = flash_q;
        cnt_d    = cnt_q;
        finished = 1'b0;
        if (abort) begin
            active_d = 1'b0;
            flash_d  = 1'b0;
            cnt_d    = '0;
        end else if (start) begin
            active_d = 1'b1;
            flash_d  = 1'b1;
            cnt_d    = '0;
        end else if (active_q && flash_tick) begin
            // The last period ends with the LED forced dark
            if (cnt_q == LAST) begin
                active_d = 1'b0;
                flash_d  = 1'b0;
                cnt_d    = '0;
                finished = 1'b1;
            end else begin
                cnt_d   = cnt_q + 1'b1;
                flash_d = ~flash_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            flash_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            flash_q  <= flash_d;
            cnt_q    <= cnt_d;
        end
    end

    assign done_flash = flash_q;

endmodule

// File: rtl/countdown_timer_fsm.sv
// Countdown timer: load, count, pause, flash on completion.
// Define TIMER_ADD30_EN to add the add_time port and quick-start logic.
module countdown_timer_fsm
    import timer_pkg::*;
#(
    parameter int TIME_W       = 8,
    parameter int MAX_TIME     = 255,
    parameter int FLASH_CYCLES = 10
`ifdef TIMER_ADD30_EN
    ,
    parameter int ADD_STEP     = 30
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              flash_tick,
    input  logic              start_pause,
    input  logic              clear,
    input  logic [TIME_W-1:0] set_val,
`ifdef TIMER_ADD30_EN
    input  logic              add_time,
`endif
    output logic [TIME_W-1:0] time_out,
    output logic [STATE_W-1:0] state_out,
    output logic              running,
    output logic              done,
    output logic              done_flash
);

    localparam logic [TIME_W-1:0] MAX_T = TIME_W'(MAX_TIME);

`ifdef TIMER_ADD30_EN
    localparam logic [TIME_W-1:0] ADD_T =
        (ADD_STEP > MAX_TIME) ? MAX_T : TIME_W'(ADD_STEP);

    function automatic logic [TIME_W-1:0] sat_add(
        input logic [TIME_W-1:0] a
    );
        logic [TIME_W:0] s;
        s = {1'b0, a} + {1'b0, ADD_T};
        return (s > {1'b0, MAX_T}) ? MAX_T : s[TIME_W-1:0];
    endfunction
`endif

    state_t            state_q, state_d;
    logic [TIME_W-1:0] preset_q, preset_d;
    logic [TIME_W-1:0] rem_q, rem_d;
    logic [TIME_W-1:0] time_out_q, time_out_d;
    logic              running_q, running_d;
    logic              done_q, done_d;

    logic [TIME_W-1:0] load_v;
    logic              zero_hit;
    logic              flash_abort;
    logic              flash_start;
    logic              flash_finished;

    assign load_v   = (set_val > MAX_T) ? MAX_T : set_val;
    assign zero_hit = tick && (rem_q == TIME_W'(1));

    always_comb begin
        state_d     = state_q;
        preset_d    = preset_q;
        rem_d       = rem_q;
        flash_abort = 1'b0;
        if (clear) begin
            state_d     = IDLE;
            preset_d    = '0;
            rem_d       = '0;
            flash_abort = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_pause) begin
                        preset_d = load_v;
                        rem_d    = load_v;
                        if (load_v != '0) state_d = LOADED;
                    end
                end
                LOADED: begin
                    if (start_pause) state_d = COUNTING;
                end
                COUNTING: begin
                    // Reaching zero outranks a simultaneous pause request
                    if (zero_hit) begin
                        rem_d   = '0;
                        state_d = DONE;
                    end else begin
                        if (tick && rem_q != '0) rem_d = rem_q - 1'b1;
                        if (start_pause) state_d = PAUSED;
                    end
                end
                PAUSED: begin
                    if (start_pause) state_d = COUNTING;
                end
                DONE: begin
                    if (start_pause) begin
                        flash_abort = 1'b1;
                        state_d     = LOADED;
                        rem_d       = preset_q;
                    end else if (flash_finished) begin
                        state_d = LOADED;
                        rem_d   = preset_q;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    preset_d    = '0;
                    rem_d       = '0;
                    flash_abort = 1'b1;
                end
            endcase
        end

`ifdef TIMER_ADD30_EN
        if (!clear && add_time) begin
            case (state_q)
                IDLE: begin
                    if (!start_pause) begin
                        preset_d = ADD_T;
                        rem_d    = ADD_T;
                        state_d  = COUNTING;
                    end
                end
                LOADED: begin
                    preset_d = sat_add(preset_q);
                    rem_d    = sat_add(preset_q);
                end
                COUNTING: begin
                    if (zero_hit) begin
                        rem_d   = ADD_T - 1'b1;
                        state_d = COUNTING;
                    end else begin
                        rem_d = sat_add(rem_d);
                    end
                end
                PAUSED: rem_d = sat_add(rem_q);
                default: ;
            endcase
        end
`endif

        flash_start = (state_d == DONE) && (state_q != DONE);

        case (state_d)
            LOADED:           time_out_d = preset_d;
            COUNTING, PAUSED: time_out_d = rem_d;
            default:          time_out_d = '0;
        endcase
        running_d = (state_d == COUNTING);
        done_d    = flash_start;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            preset_q   <= '0;
            rem_q      <= '0;
            time_out_q <= '0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            preset_q   <= preset_d;
            rem_q      <= rem_d;
            time_out_q <= time_out_d;
            running_q  <= running_d;
            done_q     <= done_d;
        end
    end

    done_flasher #(
        .FLASH_CYCLES (FLASH_CYCLES)
    ) u_flasher (
        .clk        (clk),
        .reset      (reset),
        .start      (flash_start),
        .abort      (flash_abort),
        .flash_tick (flash_tick),
        .done_flash (done_flash),
        .finished   (flash_finished)
    );

    assign time_out  = time_out_q;
    assign state_out = state_q;
    assign running   = running_q;
    assign done      = done_q;

endmodule

// File: tb/tb_countdown_timer_fsm.sv
// Randomized and directed bench for countdown_timer_fsm (default build)
// against a behavioural model, with literal pins on key scenarios.
module tb_countdown_timer_fsm;

    localparam int TW   = 8;
    localparam int MAXT = 99;
    localparam int FC   = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          tick = 1'b0;
    logic          flash_tick = 1'b0;
    logic          start_pause = 1'b0;
    logic          clear = 1'b0;
    logic [TW-1:0] set_val = '0;
    logic [TW-1:0] time_out;
    logic [2:0]    state_out;
    logic          running;
    logic          done;
    logic          done_flash;

    int total = 0;
    int bad = 0;

    // Model state: st uses the spec encodings 0..4
    int m_st = 0, m_pre = 0, m_rem = 0, m_flash = 0, m_fcnt = 0, m_done = 0;

    always #5 clk = ~clk;

    countdown_timer_fsm #(
        .TIME_W       (TW),
        .MAX_TIME     (MAXT),
        .FLASH_CYCLES (FC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .flash_tick  (flash_tick),
        .start_pause (start_pause),
        .clear       (clear),
        .set_val     (set_val),
        .time_out    (time_out),
        .state_out   (state_out),
        .running     (running),
        .done        (done),
        .done_flash  (done_flash)
    );

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_st = 0; m_pre = 0; m_rem = 0;
            m_flash = 0; m_fcnt = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (clear) begin
                m_st = 0; m_pre = 0; m_rem = 0; m_flash = 0;
            end else if (m_st == 0) begin
                if (start_pause) begin
                    m_pre = (int'(set_val) > MAXT) ? MAXT : int'(set_val);
                    m_rem = m_pre;
                    if (m_pre != 0) m_st = 1;
                end
            end else if (m_st == 1) begin
                if (start_pause) m_st = 2;
            end else if (m_st == 2) begin
                if (tick && m_rem == 1) begin
                    m_rem = 0; m_st = 4; m_done = 1;
                    m_flash = 1; m_fcnt = 0;
                end else begin
                    if (tick && m_rem > 0) m_rem = m_rem - 1;
                    if (start_pause) m_st = 3;
                end
            end else if (m_st == 3) begin
                if (start_pause) m_st = 2;
            end else if (m_st == 4) begin
                if (start_pause) begin
                    m_flash = 0; m_st = 1; m_rem = m_pre;
                end else if (flash_tick) begin
                    m_fcnt = m_fcnt + 1;
                    if (m_fcnt == 2 * FC) begin
                        m_flash = 0; m_st = 1; m_rem = m_pre;
                    end else begin
                        m_flash = 1 - m_flash;
                    end
                end
            end
        end
    end

    function automatic int exp_time();
        if (m_st == 1) return m_pre;
        if (m_st == 2 || m_st == 3) return m_rem;
        return 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cyc_time_out", 32'(time_out), exp_time());
        chk("cyc_state", 32'(state_out), m_st);
        chk("cyc_running", 32'(running), (m_st == 2) ? 1 : 0);
        chk("cyc_done", 32'(done), m_done);
        chk("cyc_done_flash", 32'(done_flash), m_flash);
    end

    task automatic step(input bit sp, input bit tk, input bit ft,
                        input bit cl, input logic [TW-1:0] sv);
        @(negedge clk);
        start_pause = sp;
        tick = tk;
        flash_tick = ft;
        clear = cl;
        set_val = sv;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_time", 32'(time_out), 0);
        chk("rst_state", 32'(state_out), 0);
        chk("rst_flash", 32'(done_flash), 0);

        step(1, 0, 0, 0, 8'd5); settle();
        chk("load5_time", 32'(time_out), 5);
        chk("load5_state", 32'(state_out), 1);
        step(1, 0, 0, 0, 8'd0); settle();
        chk("go_state", 32'(state_out), 2);
        chk("go_running", 32'(running), 1);
        for (int i = 1; i <= 4; i++) begin
            step(0, 1, 0, 0, 8'd0); settle();
            chk("count_time", 32'(time_out), 5 - i);
        end
        step(0, 1, 0, 0, 8'd0); settle();
        chk("zero_state", 32'(state_out), 4);
        chk("zero_done", 32'(done), 1);
        chk("zero_flash", 32'(done_flash), 1);
        chk("zero_time", 32'(time_out), 0);
        step(0, 0, 0, 0, 8'd0); settle();
        chk("done_once", 32'(done), 0);
        for (int i = 1; i <= 2 * FC; i++) begin
            step(0, 0, 1, 0, 8'd0); settle();
            if (i == 1) chk("flash_t1", 32'(done_flash), 0);
            if (i == 2) chk("flash_t2", 32'(done_flash), 1);
            if (i == 2 * FC - 1) chk("flash_hold", 32'(state_out), 4);
        end
        chk("reload_state", 32'(state_out), 1);
        chk("reload_time", 32'(time_out), 5);
        chk("reload_flash", 32'(done_flash), 0);

        step(0, 0, 0, 1, 8'd0);
        step(1, 0, 0, 0, 8'd200); settle();
        chk("sat_time", 32'(time_out), 99);
        step(0, 0, 0, 1, 8'd0);
        step(1, 0, 0, 0, 8'd0); settle();
        chk("zero_load_state", 32'(state_out), 0);

        step(1, 0, 0, 0, 8'd3);
        step(1, 0, 0, 0, 8'd0);
        step(1, 1, 0, 0, 8'd0); settle();
        chk("pause_tick_time", 32'(time_out), 2);
        chk("pause_tick_state", 32'(state_out), 3);
        step(0, 1, 0, 0, 8'd0);
        step(0, 1, 0, 0, 8'd0); settle();
        chk("paused_hold", 32'(time_out), 2);
        step(1, 0, 0, 0, 8'd0); settle();
        chk("resume_state", 32'(state_out), 2);
        step(0, 1, 0, 0, 8'd0); settle();
        chk("at_one", 32'(time_out), 1);
        step(1, 1, 0, 0, 8'd0); settle();
        chk("zero_vs_pause", 32'(state_out), 4);
        chk("zero_vs_pause_done", 32'(done), 1);
        step(1, 0, 0, 0, 8'd0); settle();
        chk("abort_state", 32'(state_out), 1);
        chk("abort_flash", 32'(done_flash), 0);
        chk("abort_time", 32'(time_out), 3);

        step(0, 0, 0, 1, 8'd0);
        step(1, 0, 0, 0, 8'd40);
        step(1, 0, 0, 0, 8'd0);
        step(0, 0, 0, 0, 8'd0);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("async_time", 32'(time_out), 0);
        chk("async_state", 32'(state_out), 0);
        chk("async_running", 32'(running), 0);
        @(negedge clk);
        reset = 1'b0;

        step(1, 0, 0, 0, 8'd40);
        step(1, 0, 0, 0, 8'd0);
        step(1, 0, 0, 0, 8'd0);
        step(0, 0, 0, 1, 8'd0); settle();
        chk("clear_paused", 32'(state_out), 0);

        for (int n = 0; n < 4000; n++) begin
            int sp_div;
            sp_div = (n < 2000) ? 10 : 60;
            step(($urandom % sp_div) == 0, ($urandom % 3) == 0,
                 ($urandom % 2) == 0, ($urandom % 90) == 0,
                 (($urandom % 4) == 0) ? 8'($urandom) : 8'($urandom % 8));
        end
        step(0, 0, 0, 0, 8'd0);
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
